mul_hilo_sequencer: RTL



---
 rtl/mul_hilo_sequencer_if.sv | 22 ++
 rtl/mul_hilo_sequencer.sv | 87 ++++++++
 2 files changed

// File: rtl/mul_hilo_sequencer_if.sv
// mul_hilo_sequencer_if: operand/product/handshake bundle between control unit, sequencer and Booth multiplier
interface mul_hilo_sequencer_if;
   logic        start;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic [31:0] mul_x;
   logic [31:0] mul_y;
   logic [63:0] mul_z;
   logic        busy;
   logic        done;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        fits32;
   modport slave (
      input  start, a_in, b_in, mul_z,
      output mul_x, mul_y, busy, done, hi_out, lo_out, fits32
   );
   modport master (
      output start, a_in, b_in, mul_z,
      input  mul_x, mul_y, busy, done, hi_out, lo_out, fits32
   );
endinterface

// File: rtl/mul_hilo_sequencer.sv
// mul_hilo_sequencer: registers operands for the Booth multiplier, waits SETTLE_CYCLES, captures HI/LO.
// Optional MUL_ZERO_SKIP_EN: a zero operand completes in one cycle without waiting on the multiplier.
module mul_hilo_sequencer #(
   parameter int SETTLE_CYCLES = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   mul_hilo_sequencer_if.slave bus
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] x_q, x_d, y_q, y_d, hi_q, hi_d, lo_q, lo_d;
   logic        fits_q, fits_d, done_q, done_d;
   logic        zero_op;
   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("SETTLE_CYCLES must be within 1..15");
   end
`ifdef MUL_ZERO_SKIP_EN
   assign zero_op = (bus.a_in == 32'd0) || (bus.b_in == 32'd0);
`else
   assign zero_op = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      fits_d  = fits_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         if (bus.start) begin
            x_d = bus.a_in;
            y_d = bus.b_in;
            if (zero_op) begin
               hi_d   = 32'd0;
               lo_d   = 32'd0;
               fits_d = 1'b1;
               done_d = 1'b1;
            end else begin
               cnt_d   = 4'(SETTLE_CYCLES);
               state_d = WAIT;
            end
         end
      end else begin
         cnt_d = cnt_q - 4'd1;
         // counter reaching 1 means the product has had SETTLE_CYCLES edges to settle
         if (cnt_q == 4'd1) begin
            hi_d    = bus.mul_z[63:32];
            lo_d    = bus.mul_z[31:0];
            fits_d  = bus.mul_z[63:32] == {32{bus.mul_z[31]}};
            done_d  = 1'b1;
            state_d = IDLE;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         x_q     <= 32'd0;
         y_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         fits_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         fits_q  <= fits_d;
         done_q  <= done_d;
      end
   end
   assign bus.mul_x  = x_q;
   assign bus.mul_y  = y_q;
   assign bus.busy   = state_q == WAIT;
   assign bus.done   = done_q;
   assign bus.hi_out = hi_q;
   assign bus.lo_out = lo_q;
   assign bus.fits32 = fits_q;
endmodule
